// File: rtl/b01_word_sink.sv
// rtl/b01_word_sink.sv - deserializes b01 outp/overflw into tagged words behind a 2-entry FIFO
// Head FIFO entry drives the word outputs directly, so every output is a flop.
module b01_word_sink #(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  input  logic              outp,
  input  logic              overflw,
  output logic [WORD_W-1:0] word_data,
  output logic              word_ovf,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [CNT_W-1:0]  ovf_count,
  output logic [CNT_W-1:0]  drop_count,
  output logic              busy
);

  localparam int IW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORD_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t            state;
  logic [IW-1:0]     idx;
  logic [WORD_W-1:0] shreg;
  logic              acc;
  logic [WORD_W-1:0] tail_data;
  logic              tail_ovf;
  logic              tail_valid;

  logic              done;
  logic              pop;
  logic              drop;
  logic [WORD_W-1:0] new_data;
  logic              new_ovf;

  assign done    = in_valid && (state == COLLECT) && (idx == LAST_IDX);
  assign pop     = word_valid && word_ready;
  assign drop    = done && word_valid && tail_valid && !pop;
  assign new_ovf = acc | overflw;
  assign busy    = (state == COLLECT);

  // The final bit never lands in shreg; it is merged here on completion.
  always_comb begin
    new_data = shreg;
    new_data[WORD_W-1] = outp;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      idx        <= '0;
      shreg      <= '0;
      acc        <= 1'b0;
      word_data  <= '0;
      word_ovf   <= 1'b0;
      word_valid <= 1'b0;
      tail_data  <= '0;
      tail_ovf   <= 1'b0;
      tail_valid <= 1'b0;
      ovf_count  <= '0;
      drop_count <= '0;
    end else if (clear) begin
      state      <= IDLE;
      idx        <= '0;
      shreg      <= '0;
      acc        <= 1'b0;
      word_data  <= '0;
      word_ovf   <= 1'b0;
      word_valid <= 1'b0;
      tail_data  <= '0;
      tail_ovf   <= 1'b0;
      tail_valid <= 1'b0;
      ovf_count  <= '0;
      drop_count <= '0;
    end else begin
      if (in_valid) begin
        if (done) begin
          state <= IDLE;
          idx   <= '0;
          shreg <= '0;
          acc   <= 1'b0;
        end else begin
          state      <= COLLECT;
          shreg[idx] <= outp;
          idx        <= idx + 1'b1;
          acc        <= acc | overflw;
        end
      end

      // Pop shifts the tail forward; a concurrent push fills the freed slot.
      if (pop) begin
        if (tail_valid) begin
          word_data  <= tail_data;
          word_ovf   <= tail_ovf;
          word_valid <= 1'b1;
          if (done) begin
            tail_data <= new_data;
            tail_ovf  <= new_ovf;
          end else begin
            tail_data  <= '0;
            tail_ovf   <= 1'b0;
            tail_valid <= 1'b0;
          end
        end else if (done) begin
          word_data  <= new_data;
          word_ovf   <= new_ovf;
          word_valid <= 1'b1;
        end else begin
          word_data  <= '0;
          word_ovf   <= 1'b0;
          word_valid <= 1'b0;
        end
      end else if (done) begin
        if (!word_valid) begin
          word_data  <= new_data;
          word_ovf   <= new_ovf;
          word_valid <= 1'b1;
        end else if (!tail_valid) begin
          tail_data  <= new_data;
          tail_ovf   <= new_ovf;
          tail_valid <= 1'b1;
        end
      end

      if (in_valid && overflw && (ovf_count != CNT_MAX))
        ovf_count <= ovf_count + 1'b1;
      if (drop && (drop_count != CNT_MAX))
        drop_count <= drop_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_b01_word_sink.sv
// tb/tb_b01_word_sink.sv - scoreboard bench for b01_word_sink with directed and random stimulus
module tb_b01_word_sink;
  localparam int W = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic clear = 1'b0;
  logic in_valid = 1'b0;
  logic outp = 1'b0;
  logic overflw = 1'b0;
  logic word_ready = 1'b0;

  logic [W-1:0] a_data, b_data;
  logic         a_ovf, b_ovf, a_valid, b_valid, a_busy, b_busy;
  logic [7:0]   a_ovfc, a_drop;
  logic [1:0]   b_ovfc, b_drop;

  b01_word_sink #(.WORD_W(W), .CNT_W(8)) dut_a (
    .clock(clock), .reset(reset), .clear(clear), .in_valid(in_valid),
    .outp(outp), .overflw(overflw), .word_data(a_data), .word_ovf(a_ovf),
    .word_valid(a_valid), .word_ready(word_ready), .ovf_count(a_ovfc),
    .drop_count(a_drop), .busy(a_busy));

  b01_word_sink #(.WORD_W(W), .CNT_W(2)) dut_b (
    .clock(clock), .reset(reset), .clear(clear), .in_valid(in_valid),
    .outp(outp), .overflw(overflw), .word_data(b_data), .word_ovf(b_ovf),
    .word_valid(b_valid), .word_ready(word_ready), .ovf_count(b_ovfc),
    .drop_count(b_drop), .busy(b_busy));

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Reference model: pending bits, accepted words in order, unbounded event counts.
  logic [W:0] sb[$];
  bit         cur[$];
  bit         acc = 1'b0;
  int         ovf_n = 0;
  int         drop_n = 0;

  function automatic int sat(input int n, input int m);
    return (n > m) ? m : n;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    sb.delete();
    cur.delete();
    acc = 1'b0;
    ovf_n = 0;
    drop_n = 0;
  endtask

  task automatic model_step(input bit iv, input bit o, input bit ov, input bit clr);
    logic [W-1:0] w;
    if (clr) begin
      model_clear();
      return;
    end
    if (!iv) return;
    if (ov) ovf_n++;
    acc = acc | ov;
    cur.push_back(o);
    if (cur.size() == W) begin
      for (int i = 0; i < W; i++) w[i] = cur[i];
      if (sb.size() < 2) sb.push_back({acc, w});
      else drop_n++;
      cur.delete();
      acc = 1'b0;
    end
  endtask

  // Inputs change 1 time unit after the rising edge; the model then sees that edge's result.
  task automatic step(input bit iv, input bit o, input bit ov, input bit rdy, input bit clr);
    in_valid = iv; outp = o; overflw = ov; word_ready = rdy; clear = clr;
    @(posedge clock);
    #1;
    model_step(iv, o, ov, clr);
  endtask

  task automatic send_word(input logic [W-1:0] d, input logic [W-1:0] ovm, input logic [W-1:0] rdym);
    for (int i = 0; i < W; i++) step(1'b1, d[i], ovm[i], rdym[i], 1'b0);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, rdy, 1'b0);
  endtask

  // Monitor: checks every negedge and retires the head on an observed handshake.
  initial begin
    forever begin
      @(negedge clock);
      chk("valid", int'(a_valid), int'(sb.size() != 0));
      chk("b_valid", int'(b_valid), int'(sb.size() != 0));
      if (sb.size() != 0) begin
        chk("data", int'(a_data), int'(sb[0][W-1:0]));
        chk("ovf_tag", int'(a_ovf), int'(sb[0][W]));
        chk("b_data", int'(b_data), int'(sb[0][W-1:0]));
      end else begin
        chk("empty_data", int'(a_data), 0);
        chk("empty_ovf", int'(a_ovf), 0);
      end
      chk("busy", int'(a_busy), int'(cur.size() != 0));
      chk("ovf_count", int'(a_ovfc), sat(ovf_n, 255));
      chk("drop_count", int'(a_drop), sat(drop_n, 255));
      chk("b_ovf_count", int'(b_ovfc), sat(ovf_n, 3));
      chk("b_drop_count", int'(b_drop), sat(drop_n, 3));
      if (a_valid && word_ready && sb.size() != 0) void'(sb.pop_front());
    end
  end

  initial begin
    logic [W-1:0] d;
    @(posedge clock);
    #1;
    chk("reset_valid", int'(a_valid), 0);
    chk("reset_data", int'(a_data), 0);
    chk("reset_counts", int'({a_ovfc, a_drop}), 0);
    chk("reset_busy", int'(a_busy), 0);
    @(posedge clock);
    #1;
    reset = 1'b1;

    // Basic word 0x4D, popped the cycle it appears.
    send_word(8'h4D, 8'h00, 8'hFF);
    chk("t1_valid", int'(a_valid), 1);
    chk("t1_data", int'(a_data), 'h4D);
    chk("t1_ovf", int'(a_ovf), 0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t1_popped", int'(a_valid), 0);

    // Overflow on bit 3 only, then a clean word.
    send_word(8'h4D, 8'h08, 8'hFF);
    chk("t2_data", int'(a_data), 'h4D);
    chk("t2_ovf", int'(a_ovf), 1);
    chk("t2_ovf_count", int'(a_ovfc), 1);
    send_word(8'hA5, 8'h00, 8'hFF);
    chk("t2_clean_ovf", int'(a_ovf), 0);
    idle(2, 1'b1);

    // Three words into a stalled FIFO: third is dropped.
    send_word(8'h11, 8'h00, 8'h00);
    send_word(8'h22, 8'h00, 8'h00);
    send_word(8'h33, 8'h00, 8'h00);
    chk("t3_drop", int'(a_drop), 1);
    chk("t3_head", int'(a_data), 'h11);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t3_second", int'(a_data), 'h22);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t3_empty", int'(a_valid), 0);

    // Full FIFO with a pop exactly when the third word completes.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t4_cleared_drop", int'(a_drop), 0);
    send_word(8'h11, 8'h00, 8'h00);
    send_word(8'h22, 8'h00, 8'h00);
    send_word(8'h44, 8'h00, 8'h80);
    chk("t4_no_drop", int'(a_drop), 0);
    chk("t4_head", int'(a_data), 'h22);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t4_third", int'(a_data), 'h44);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t4_empty", int'(a_valid), 0);

    // in_valid toggling, then async reset mid-word.
    d = 8'hC3;
    for (int i = 0; i < W; i++) begin
      step(1'b1, d[i], 1'b0, 1'b1, 1'b0);
      if (i == W - 1) chk("t5_toggle_data", int'(a_data), 'hC3);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t5_busy", int'(a_busy), 1);
    reset = 1'b0;
    model_clear();
    #1;
    chk("t5_rst_busy", int'(a_busy), 0);
    chk("t5_rst_counts", int'({a_ovfc, a_drop}), 0);
    chk("t5_rst_valid", int'(a_valid), 0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    send_word(8'h5A, 8'h00, 8'hFF);
    chk("t5_fresh", int'(a_data), 'h5A);
    idle(2, 1'b1);

    // Saturation on the 2-bit counter instance, then clear.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b0);
      chk("t6_sat", int'(b_ovfc), (i < 3) ? i + 1 : 3);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("t6_clr_ovf", int'(b_ovfc), 0);
    chk("t6_clr_a_ovf", int'(a_ovfc), 0);
    chk("t6_clr_valid", int'(a_valid), 0);
    chk("t6_clr_busy", int'(a_busy), 0);

    // Randomized traffic with alternating consumer pressure.
    for (int n = 0; n < 4000; n++) begin
      bit rdy;
      if ((n / 500) % 2 == 0) rdy = ($urandom_range(0, 9) < 8);
      else rdy = ($urandom_range(0, 9) < 1);
      step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 5) == 0), rdy, ($urandom_range(0, 999) == 0));
    end
    idle(4, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
